// File: rtl/controlador_memoria_principal.sv
// Main-memory controller behind the 2-way cache. It serializes a write-back before a line fill, with a fixed access latency.
// Optional build macro CONTROLADOR_MEM_ESTATISTICAS_EN adds saturating read/write completion counters.
module controlador_memoria_principal #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int LATENCIA = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              solicitacao_de_leitura,
    input  logic              solicitacao_de_escrita,
    input  logic [ADDR_W-1:0] endereco_leitura,
    input  logic [ADDR_W-1:0] endereco_escrita,
    input  logic [DATA_W-1:0] bloco_a_ser_escrito,
    output logic [DATA_W-1:0] bloco_lido,
    output logic              ocupado,
    output logic              pronto,
    output logic              escrita_concluida
`ifdef CONTROLADOR_MEM_ESTATISTICAS_EN
    ,
    output logic [7:0]        contador_leituras,
    output logic [7:0]        contador_escritas
`endif
);

    localparam int         PROF    = 2**ADDR_W;
    localparam logic [3:0] CNT_INI = 4'(LATENCIA - 1);

    typedef logic [DATA_W-1:0] mem_t [PROF];
    typedef enum logic [1:0] {OCIOSO, ESCREVE, LE} estado_t;

    function automatic mem_t conteudo_inicial();
        mem_t m;
        for (int i = 0; i < PROF; i++) m[i] = DATA_W'(i);
        return m;
    endfunction

    // Power-up image mem[i] = i; reset never touches the array.
    mem_t mem = conteudo_inicial();

    estado_t           estado, estado_prox;
    logic [3:0]        cnt, cnt_prox;
    logic              leitura_pendente;
    logic [ADDR_W-1:0] addr_r, addr_w;
    logic [DATA_W-1:0] data_w;
    logic              grava, le_fim, aceita;

    assign ocupado = (estado != OCIOSO);
    assign aceita  = (estado == OCIOSO) && (solicitacao_de_leitura || solicitacao_de_escrita);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
            cnt    <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        grava       = 1'b0;
        le_fim      = 1'b0;
        case (estado)
            OCIOSO: begin
                if (solicitacao_de_escrita) begin
                    estado_prox = ESCREVE;
                    cnt_prox    = CNT_INI;
                end else if (solicitacao_de_leitura) begin
                    estado_prox = LE;
                    cnt_prox    = CNT_INI;
                end
            end
            ESCREVE: begin
                if (cnt != 4'd0) begin
                    cnt_prox = cnt - 4'd1;
                end else begin
                    grava = 1'b1;
                    // A fill raised together with the write-back runs only after the commit.
                    if (leitura_pendente) begin
                        estado_prox = LE;
                        cnt_prox    = CNT_INI;
                    end else begin
                        estado_prox = OCIOSO;
                    end
                end
            end
            LE: begin
                if (cnt != 4'd0) begin
                    cnt_prox = cnt - 4'd1;
                end else begin
                    le_fim      = 1'b1;
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leitura_pendente  <= 1'b0;
            addr_r            <= '0;
            addr_w            <= '0;
            data_w            <= '0;
            bloco_lido        <= '0;
            pronto            <= 1'b0;
            escrita_concluida <= 1'b0;
        end else begin
            pronto            <= le_fim;
            escrita_concluida <= grava;
            if (aceita) begin
                leitura_pendente <= solicitacao_de_escrita && solicitacao_de_leitura;
                addr_r           <= endereco_leitura;
                addr_w           <= endereco_escrita;
                data_w           <= bloco_a_ser_escrito;
            end
            if (le_fim) bloco_lido <= mem[addr_r];
        end
    end

    // grava is forced low while reset holds the FSM in OCIOSO, so an aborted write never lands.
    always_ff @(posedge clock) begin
        if (grava) mem[addr_w] <= data_w;
    end

`ifdef CONTROLADOR_MEM_ESTATISTICAS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador_leituras <= '0;
            contador_escritas <= '0;
        end else begin
            if (pronto && contador_leituras != 8'hFF) contador_leituras <= contador_leituras + 8'd1;
            if (escrita_concluida && contador_escritas != 8'hFF) contador_escritas <= contador_escritas + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_controlador_memoria_principal.sv
// Directed bench for controlador_memoria_principal: a reference array model feeds a queue of expected read data.
module tb_controlador_memoria_principal;

    localparam int LAT = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       solicitacao_de_leitura = 1'b0;
    logic       solicitacao_de_escrita = 1'b0;
    logic [4:0] endereco_leitura = '0;
    logic [4:0] endereco_escrita = '0;
    logic [7:0] bloco_a_ser_escrito = '0;
    logic [7:0] bloco_lido;
    logic       ocupado, pronto, escrita_concluida;
`ifdef CONTROLADOR_MEM_ESTATISTICAS_EN
    logic [7:0] contador_leituras, contador_escritas;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [7:0] modelo [32];
    logic [7:0] esperado_q [$];

    controlador_memoria_principal #(.ADDR_W(5), .DATA_W(8), .LATENCIA(LAT)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .solicitacao_de_leitura (solicitacao_de_leitura),
        .solicitacao_de_escrita (solicitacao_de_escrita),
        .endereco_leitura       (endereco_leitura),
        .endereco_escrita       (endereco_escrita),
        .bloco_a_ser_escrito    (bloco_a_ser_escrito),
        .bloco_lido             (bloco_lido),
        .ocupado                (ocupado),
        .pronto                 (pronto),
        .escrita_concluida      (escrita_concluida)
`ifdef CONTROLADOR_MEM_ESTATISTICAS_EN
        ,
        .contador_leituras      (contador_leituras),
        .contador_escritas      (contador_escritas)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one edge (the accepting edge), then drop both lines.
    task automatic pede(input bit rd, input bit wr, input logic [4:0] ar, input logic [4:0] aw,
                        input logic [7:0] d);
        @(negedge clock);
        solicitacao_de_leitura = rd;
        solicitacao_de_escrita = wr;
        endereco_leitura       = ar;
        endereco_escrita       = aw;
        bloco_a_ser_escrito    = d;
        @(posedge clock); #1;
        solicitacao_de_leitura = 1'b0;
        solicitacao_de_escrita = 1'b0;
    endtask

    task automatic le(input logic [4:0] a);
        esperado_q.push_back(modelo[a]);
        pede(1'b1, 1'b0, a, 5'd0, 8'd0);
    endtask

    // Count edges to the completion pulse; on a read, pop the scoreboard and compare the data.
    task automatic espera(input string tag, input bit leitura, input int lat, input bit ocup_fim);
        int  n = 0;
        bit  visto = 1'b0;
        while (!visto && n < 40) begin
            @(posedge clock); #1;
            n++;
            visto = leitura ? pronto : escrita_concluida;
            if (!visto) check({tag, "_ocupado"}, 32'(ocupado), 32'd1);
        end
        check({tag, "_latencia"}, 32'(n), 32'(lat));
        check({tag, "_ocupado_fim"}, 32'(ocupado), 32'(ocup_fim));
        check({tag, "_pulsos_juntos"}, 32'(pronto & escrita_concluida), 32'd0);
        if (leitura && visto) begin
            if (esperado_q.size() == 0) check({tag, "_fila_vazia"}, 32'd1, 32'd0);
            else check({tag, "_dado"}, 32'(bloco_lido), 32'(esperado_q.pop_front()));
        end
    endtask

    initial begin
        logic [7:0] retido;
        for (int i = 0; i < 32; i++) modelo[i] = 8'(i);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_escrita", 32'(escrita_concluida), 32'd0);
        check("rst_bloco", 32'(bloco_lido), 32'd0);
        @(negedge clock) reset = 1'b0;

        // Read-only at 9
        le(5'd9);
        espera("le9", 1'b1, LAT, 1'b0);
        retido = bloco_lido;
        @(posedge clock); #1;
        check("le9_pulso_cai", 32'(pronto), 32'd0);
        check("le9_retem", 32'(bloco_lido), 32'(retido));

        // Write-only 4 <- A5, then read back
        modelo[4] = 8'hA5;
        pede(1'b0, 1'b1, 5'd0, 5'd4, 8'hA5);
        espera("esc4", 1'b0, LAT, 1'b0);
        le(5'd4);
        check("le4_sem_pulso_escrita", 32'(escrita_concluida), 32'd0);
        espera("le4", 1'b1, LAT, 1'b0);

        // Simultaneous write and read of the same address
        modelo[2] = 8'h3C;
        esperado_q.push_back(8'h3C);
        pede(1'b1, 1'b1, 5'd2, 5'd2, 8'h3C);
        espera("wr2_esc", 1'b0, LAT, 1'b1);
        espera("wr2_le", 1'b1, LAT, 1'b0);

        // Inputs wiggled while busy must be ignored
        le(5'd6);
        solicitacao_de_leitura = 1'b1;
        solicitacao_de_escrita = 1'b1;
        endereco_leitura       = 5'd31;
        endereco_escrita       = 5'd31;
        bloco_a_ser_escrito    = 8'h77;
        @(posedge clock); #1;
        solicitacao_de_leitura = 1'b0;
        solicitacao_de_escrita = 1'b0;
        espera("ignora", 1'b1, LAT - 1, 1'b0);
        le(5'd31);
        espera("le31", 1'b1, LAT, 1'b0);

        // Reset one cycle before the write to 7 would commit
        pede(1'b0, 1'b1, 5'd0, 5'd7, 8'hFF);
        repeat (LAT - 1) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_ocupado", 32'(ocupado), 32'd0);
        check("abort_bloco", 32'(bloco_lido), 32'd0);
        check("abort_pronto", 32'(pronto), 32'd0);
        check("abort_escrita", 32'(escrita_concluida), 32'd0);
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        le(5'd7);
        espera("le7", 1'b1, LAT, 1'b0);

        // Random back-to-back mix against the model
        for (int i = 0; i < 8; i++) begin
            int         op = $urandom_range(0, 2);
            logic [4:0] ar = 5'($urandom_range(0, 31));
            logic [4:0] aw = 5'($urandom_range(0, 31));
            logic [7:0] d  = 8'($urandom_range(0, 255));
            if (op == 0) begin
                le(ar);
                espera("mix_le", 1'b1, LAT, 1'b0);
            end else begin
                modelo[aw] = d;
                if (op == 2) esperado_q.push_back(modelo[ar]);
                pede(op == 2, 1'b1, ar, aw, d);
                espera("mix_esc", 1'b0, LAT, op == 2);
                if (op == 2) espera("mix_wr_le", 1'b1, LAT, 1'b0);
            end
        end

`ifdef CONTROLADOR_MEM_ESTATISTICAS_EN
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        check("cnt_rst_le", 32'(contador_leituras), 32'd0);
        for (int i = 0; i < 300; i++) begin
            le(5'(i));
            espera("sat_le", 1'b1, LAT, 1'b0);
        end
        @(posedge clock); #1;
        check("cnt_leituras", 32'(contador_leituras), 32'd255);
        check("cnt_escritas", 32'(contador_escritas), 32'd0);
`endif

        check("fila_vazia_fim", 32'(esperado_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
